dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port, replacing the ideal single-cycle data memory with a handshaked, multi-cycle word-addressed RAM.
- Accepts one load/store request at a time on a valid/ready request channel, waits a configurable number of cycles, then returns read data and status on a valid/ready response channel.
- Sits between the core's load/store path (address = ALU result, write data = rs2) and the RAM array it owns internally.

Parameters:
- DW, 32, data and address width.
- MEM_SIZE_IN_KB, 1, memory size in KiB.
- NO_OF_REGS, MEM_SIZE_IN_KB*1024/4, number of 32-bit words.
- WAIT_STATES, 2, extra cycles between accept and response (0..15).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  DW  byte address.
- req_wdata_i  in  DW  store data.
- req_be_i  in  4  byte enables for stores; ignored for loads.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  core accepts the response.
- rsp_rdata_o  out  DW  load data; 0 for stores.
- rsp_err_o  out  1  access error; see Optional Feature.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE; counter = 0.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE: req_ready_o=1. A handshake (req_valid_i & req_ready_o) latches we, addr, wdata and be. Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: req_ready_o=0. The counter counts up from 0. After WAIT_STATES cycles in WAIT, go to ACCESS.
  - ACCESS (one cycle):
    - Store: write enabled bytes into word addr[ADDRW+1:2], with ADDRW=$clog2(NO_OF_REGS).
    - Load: register the word into rsp_rdata_o.
    - Go to RESP.
  - RESP: rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i=1. On the response handshake, go to IDLE and drive rsp_valid_o, rsp_rdata_o and rsp_err_o to 0.
- Latency:
  - Accept to rsp_valid_o high = WAIT_STATES+2 cycles.
  - With rsp_ready_i held high, a new request can be accepted in the cycle after the response handshake.
- Outstanding requests: at most one; req_ready_o is low in WAIT, ACCESS and RESP.
- Store byte merge: byte k of the word is written only if req_be_i[k]=1. req_be_i=0000 on a store is a legal no-op and still returns a response.
- Load data: the full word is returned; byte/half extraction and sign extension are the core's job.
- Stability: request inputs are only sampled on the handshake; changes outside the handshake are ignored.
- Reset mid-transaction:
  - The transaction is dropped and no response is issued.
  - A store already in ACCESS at the reset edge may or may not commit; the bench must not check that word.
- Address bits above the memory range are handled per Optional Feature.

Optional Feature:
- Macro: DMEM_ERR_EN
- Defined:
  - rsp_err_o=1 if addr[1:0]!=0 or addr >= MEM_SIZE_IN_KB*1024.
  - An errored store writes nothing; an errored load returns rsp_rdata_o=0.
  - Timing is unchanged.
- Undefined:
  - rsp_err_o is tied to 0.
  - addr[1:0] is ignored.
  - The word index wraps modulo NO_OF_REGS, e.g. 0x400 aliases 0x000 at 1 KiB.

Test Plan:
- Reset then idle: rst_i low 3 cycles, then high -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Store then load, WAIT_STATES=2:
  - Store 0xDEADBEEF to 0x010 with be=1111 -> rsp_valid_o rises 4 cycles after accept with rdata=0.
  - Load 0x010 -> rdata=0xDEADBEEF.
- Byte-enable merge:
  - Store 0x11223344 to 0x020 with be=1111, then 0xAABBCCDD with be=0101.
  - Load 0x020 -> 0x11BB33DD.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o -> rsp_valid_o and rdata stable, req_ready_o=0; a request offered during that time is not accepted until the cycle after the response handshake.
- WAIT_STATES=0 back-to-back: 4 loads with rsp_ready_i=1 -> each response 2 cycles after its accept, one accept every 3 cycles.
- DMEM_ERR_EN:
  - Defined: load 0x402 -> rsp_err_o=1, rdata=0; store to 0x402 leaves word 0 unchanged.
  - Undefined: load 0x400 returns word 0 with rsp_err_o=0.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the core's data-memory port. It holds one
// load/store at a time, waits WAIT_STATES extra cycles, performs the RAM
// access in a single ACCESS cycle and then presents the result until the
// core takes it.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   : misaligned or out-of-range accesses raise rsp_err_o. An errored
//               store writes nothing and an errored load returns zero.
//   undefined : rsp_err_o is always 0, addr[1:0] is ignored and the word
//               index wraps modulo NO_OF_REGS.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  responder idle and able to accept a request
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address (DW bits)
//   req_wdata_i  store data (DW bits)
//   req_be_i     store byte enables (ignored for loads)
//   rsp_valid_o  response valid
//   rsp_ready_i  core accepts the response
//   rsp_rdata_o  load data, 0 for stores (DW bits)
//   rsp_err_o    access error
//
// The byte-lane logic assumes DW = 32 (four byte enables).
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int WAIT_STATES    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [3:0]    req_be_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
);

    localparam int ADDRW = $clog2(NO_OF_REGS);

    // Value of the wait counter on the last WAIT cycle. With WAIT_STATES = 0
    // the WAIT state is never entered, so the value is irrelevant there.
    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [3:0]      be_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;

    // Word-addressed RAM; contents survive reset.
    logic [DW-1:0]   mem_q [NO_OF_REGS];

    logic [ADDRW-1:0] word_idx_d;
    logic             acc_err_d;
    logic             wr_en_d;
    logic [3:0]       byte_we_d;

    // Taking only the index bits gives the modulo-NO_OF_REGS wrap for free.
    assign word_idx_d = addr_q[ADDRW+1:2];

`ifdef DMEM_ERR_EN
    localparam logic [DW-1:0] MEM_BYTES = DW'(MEM_SIZE_IN_KB * 1024);

    assign acc_err_d = (addr_q[1:0] != 2'b00) || (addr_q >= MEM_BYTES);
`else
    assign acc_err_d = 1'b0;

    // Byte offset and bits above the RAM range play no part in this build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[DW-1:ADDRW+2], addr_q[1:0]};
`endif

    assign wr_en_d = (state_q == S_ACCESS) && we_q && !acc_err_d;

    // Per-lane write enables for the byte merge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign byte_we_d[gi] = wr_en_d & be_q[gi];
        end
    endgenerate

    // RAM write port, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (byte_we_d[k]) begin
                mem_q[word_idx_d][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        we_q        <= req_we_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        be_q        <= req_be_i;
                        cnt_q       <= 4'd0;
                        req_ready_q <= 1'b0;
                        state_q     <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WS_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ACCESS: begin
                    // Stores and errored loads both report zero data.
                    rsp_rdata_q <= (we_q || acc_err_d) ? '0 : mem_q[word_idx_d];
                    rsp_err_q   <= acc_err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share clock and reset: instance 0 with WAIT_STATES = 2 and
// instance 1 with WAIT_STATES = 0. A word-array reference model per instance
// predicts load data, error flags and latency from the access rules.
// Honours DMEM_ERR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WS0 = 2;
    localparam int WS1 = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    dmem_responder #(.WAIT_STATES(WS0)) u_dut_ws2 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_we_i    (req_we[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
        .req_be_i    (req_be[0]),
        .rsp_valid_o (rsp_valid[0]),
        .rsp_ready_i (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_err_o   (rsp_err[0])
    );

    dmem_responder #(.WAIT_STATES(WS1)) u_dut_ws0 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_we_i    (req_we[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
        .req_be_i    (req_be[1]),
        .rsp_valid_o (rsp_valid[1]),
        .rsp_ready_i (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_err_o   (rsp_err[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 1 KiB = 256 words per instance.
    logic [31:0] ref_mem [2][256];

    function automatic bit ref_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a % 4 != 0) || (a >= 1024);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [31:0] ref_load(input int i, input logic [31:0] a);
        if (ref_err(a)) return 32'h0;
        return ref_mem[i][(a / 4) % 256];
    endfunction

    task automatic ref_store(input int i, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        int w;
        if (ref_err(a)) return;
        w = (a / 4) % 256;
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[i][w][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge. Drives the request until accepted;
    // acc is the cycle whose rising edge performs the handshake.
    task automatic start_req(input int i, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be, input string tag,
                             output int acc);
        int n = 0;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
        while (req_ready[i] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".accept"}, {31'b0, req_ready[i]}, 32'd1);
        acc = cyc;
        @(negedge clk);
        // Garbage on the request bus after the handshake must be ignored.
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom);
    endtask

    // Waits for the response, holds it off for 'hold' cycles, then takes it.
    // rc = first cycle rsp_valid is seen, hc = handshake cycle.
    task automatic wait_rsp(input int i, input int hold, input string tag,
                            output logic [31:0] rd, output logic er,
                            output int rc, output int hc);
        int n = 0;
        rsp_ready[i] = 1'b0;
        while (rsp_valid[i] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".rsp_valid"}, {31'b0, rsp_valid[i]}, 32'd1);
        check({tag, ".busy"}, {31'b0, req_ready[i]}, 32'd0);
        rc = cyc;
        rd = rsp_rdata[i];
        er = rsp_err[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'b0, rsp_valid[i]}, 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata[i], rd);
            check({tag, ".hold_err"}, {31'b0, rsp_err[i]}, {31'b0, er});
            check({tag, ".hold_busy"}, {31'b0, req_ready[i]}, 32'd0);
        end
        rsp_ready[i] = 1'b1;
        hc = cyc;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        check({tag, ".post_valid"}, {31'b0, rsp_valid[i]}, 32'd0);
        check({tag, ".post_rdata"}, rsp_rdata[i], 32'd0);
        check({tag, ".post_err"}, {31'b0, rsp_err[i]}, 32'd0);
    endtask

    // Full transaction checked against the model.
    task automatic txn(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold, input string tag,
                       output logic [31:0] rd, output logic er);
        int          acc, rc, hc;
        logic [31:0] exp_rd;
        bit          exp_er;
        exp_er = ref_err(a);
        exp_rd = we ? 32'h0 : ref_load(i, a);
        start_req(i, we, a, d, be, tag, acc);
        wait_rsp(i, hold, tag, rd, er, rc, hc);
        check({tag, ".latency"}, 32'(rc - acc), 32'((i == 0 ? WS0 : WS1) + 2));
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {31'b0, er}, {31'b0, exp_er});
        if (we) ref_store(i, a, d, be);
        $display("txn %s inst=%0d we=%0b addr=%h wdata=%h be=%b rdata=%h err=%0b lat=%0d",
                 tag, i, we, a, d, be, rd, er, rc - acc);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       a = a + 32'h400;
            1:       a = a + 32'($urandom_range(1, 3));
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        int          acc, acc2, rc, hc, got, k, seen;
        bit          adv;
        int          acc_t [4];
        int          rsp_t [4];
        logic [31:0] rd_t  [4];
        logic [31:0] exp_t [4];
        logic [31:0] rd;
        logic        er;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
            req_be[i]    = 4'h0;
            rsp_ready[i] = 1'b0;
            for (int w = 0; w < 256; w++) ref_mem[i][w] = 32'h0;
        end
        for (int j = 0; j < 4; j++) begin
            acc_t[j] = 0;
            rsp_t[j] = 0;
            rd_t[j]  = 32'h0;
        end

        // Reset then idle.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d.req_ready", i), {31'b0, req_ready[i]}, 32'd1);
            check($sformatf("reset%0d.rsp_valid", i), {31'b0, rsp_valid[i]}, 32'd0);
            check($sformatf("reset%0d.rsp_rdata", i), rsp_rdata[i], 32'd0);
            check($sformatf("reset%0d.rsp_err", i), {31'b0, rsp_err[i]}, 32'd0);
        end

        // Store then load.
        txn(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'b1111, 0, "st010", rd, er);
        txn(0, 1'b0, 32'h010, 32'h0, 4'b0000, 0, "ld010", rd, er);
        check("ld010.literal", rd, 32'hDEADBEEF);

        // Byte-enable merge, plus an all-zero-enable store as a no-op.
        txn(0, 1'b1, 32'h020, 32'h11223344, 4'b1111, 1, "st020a", rd, er);
        txn(0, 1'b1, 32'h020, 32'hAABBCCDD, 4'b0101, 0, "st020b", rd, er);
        txn(0, 1'b1, 32'h020, 32'h55555555, 4'b0000, 0, "st020nop", rd, er);
        txn(0, 1'b0, 32'h020, 32'h0, 4'b0000, 2, "ld020", rd, er);
        check("ld020.literal", rd, 32'h11BB33DD);

        // Response backpressure with a second request offered meanwhile.
        start_req(0, 1'b0, 32'h010, 32'h0, 4'b0000, "bp1", acc);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h020;
        wait_rsp(0, 5, "bp1", rd, er, rc, hc);
        check("bp1.rdata", rd, 32'hDEADBEEF);
        check("bp1.latency", 32'(rc - acc), 32'(WS0 + 2));
        start_req(0, 1'b0, 32'h020, 32'h0, 4'b0000, "bp2", acc2);
        check("bp2.accept_cycle", 32'(acc2), 32'(hc + 1));
        wait_rsp(0, 0, "bp2", rd, er, rc, hc);
        check("bp2.rdata", rd, 32'h11BB33DD);

        // WAIT_STATES = 0, four back-to-back loads with rsp_ready held high.
        for (int j = 0; j < 4; j++)
            txn(1, 1'b1, 32'h040 + 32'(4 * j), $urandom, 4'b1111, 0,
                $sformatf("b2b_init%0d", j), rd, er);
        for (int j = 0; j < 4; j++) exp_t[j] = ref_load(1, 32'h040 + 32'(4 * j));
        rsp_ready[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_be[1]    = 4'b0000;
        req_addr[1]  = 32'h040;
        req_valid[1] = 1'b1;
        k   = 0;
        got = 0;
        adv = 1'b0;
        for (int n = 0; n < 40 && got < 4; n++) begin
            if (req_valid[1] && req_ready[1] && k < 4) begin
                acc_t[k] = cyc;
                adv      = 1'b1;
            end
            if (rsp_valid[1]) begin
                rsp_t[got] = cyc;
                rd_t[got]  = rsp_rdata[1];
                got++;
            end
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                k++;
                if (k < 4) req_addr[1] = 32'h040 + 32'(4 * k);
                else       req_valid[1] = 1'b0;
            end
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        check("b2b.count", 32'(got), 32'd4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("b2b%0d.latency", j), 32'(rsp_t[j] - acc_t[j]), 32'd2);
            check($sformatf("b2b%0d.rdata", j), rd_t[j], exp_t[j]);
            if (j < 3)
                check($sformatf("b2b%0d.spacing", j), 32'(acc_t[j+1] - acc_t[j]), 32'd3);
            $display("txn b2b%0d inst=1 acc=%0d rsp=%0d rdata=%h", j, acc_t[j], rsp_t[j], rd_t[j]);
        end

        // Out-of-range / misaligned handling.
        txn(0, 1'b1, 32'h000, 32'h11111111, 4'b1111, 0, "st000", rd, er);
`ifdef DMEM_ERR_EN
        txn(0, 1'b0, 32'h402, 32'h0, 4'b0000, 0, "ld402", rd, er);
        check("ld402.err_literal", {31'b0, er}, 32'd1);
        check("ld402.rdata_literal", rd, 32'h0);
        txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'b1111, 0, "st402", rd, er);
        txn(0, 1'b0, 32'h000, 32'h0, 4'b0000, 0, "ld000", rd, er);
        check("ld000.literal", rd, 32'h11111111);
`else
        txn(0, 1'b0, 32'h400, 32'h0, 4'b0000, 0, "ld400", rd, er);
        check("ld400.literal", rd, 32'h11111111);
        check("ld400.err_literal", {31'b0, er}, 32'd0);
`endif

        // Reset in the middle of a load: dropped, no response afterwards.
        start_req(0, 1'b0, 32'h010, 32'h0, 4'b0000, "rstmid", acc);
        rst_n = 1'b0;
        #1;
        check("rstmid.req_ready", {31'b0, req_ready[0]}, 32'd1);
        check("rstmid.rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) seen++;
        end
        check("rstmid.no_response", 32'(seen), 32'd0);
        check("rstmid.idle", {31'b0, req_ready[0]}, 32'd1);

        // Randomized traffic over a pre-initialised window.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                txn(i, 1'b1, 32'h100 + 32'(4 * w), $urandom, 4'b1111, 0,
                    $sformatf("init%0d_%0d", i, w), rd, er);
        for (int t = 0; t < 45; t++) begin
            int i;
            i = (t < 30) ? 0 : 1;
            txn(i, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 3), $sformatf("rnd%0d", t), rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
